// File: rtl/led_blink_if.sv
// Control-side bundle for the LED blinker: event/clear requests in,
// LED drive and status out.
interface led_blink_if #(
   parameter int PendWidth = 3
) ();
   logic                 event_i;
   logic                 clear_i;
   logic                 led_o;
   logic                 busy_o;
   logic [PendWidth-1:0] pending_o;
   logic                 overflow_o;

   modport master (
      output event_i, clear_i,
      input  led_o, busy_o, pending_o, overflow_o
   );

   modport slave (
      input  event_i, clear_i,
      output led_o, busy_o, pending_o, overflow_o
   );
endinterface

// File: rtl/led_blink_interface.sv
// Turns one-cycle event pulses into visible LED blinks (OnCycles high, OffCycles low).
// Events arriving mid-blink are queued in a saturating counter and replayed.
module led_blink_interface #(
   parameter int OnCycles  = 8,
   parameter int OffCycles = 4,
   parameter int PendWidth = 3
) (
   input  logic       clock,
   input  logic       reset,
   led_blink_if.slave bus
);

   localparam int MaxCyc = (OnCycles > OffCycles) ? OnCycles : OffCycles;
   localparam int TimerW = (MaxCyc < 2) ? 1 : $clog2(MaxCyc);
   localparam logic [TimerW-1:0]    OnLoad  = TimerW'(OnCycles - 1);
   localparam logic [TimerW-1:0]    OffLoad = TimerW'(OffCycles - 1);
   localparam logic [PendWidth-1:0] PendMax = '1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ON   = 2'd1,
      S_OFF  = 2'd2
   } state_e;

   state_e               state_q, state_d;
   logic [TimerW-1:0]    timer_q, timer_d;
   logic [PendWidth-1:0] pend_q,  pend_d;
   logic                 ovf_q,   ovf_d;
   logic                 led_q,   led_d;
   logic                 busy_q,  busy_d;
   logic                 start;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         timer_q <= '0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
      end
   end

   // start marks the edge a blink begins; it is what consumes a pending event
   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      start   = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (pend_q != '0) begin
               state_d = S_ON;
               timer_d = OnLoad;
               start   = 1'b1;
            end
         end
         S_ON: begin
            if (timer_q != '0) begin
               timer_d = timer_q - 1'b1;
            end else begin
               state_d = S_OFF;
               timer_d = OffLoad;
            end
         end
         S_OFF: begin
            if (timer_q != '0) begin
               timer_d = timer_q - 1'b1;
            end else if (pend_q != '0) begin
               state_d = S_ON;
               timer_d = OnLoad;
               start   = 1'b1;
            end else begin
               state_d = S_IDLE;
               timer_d = '0;
            end
         end
         default: begin
            state_d = S_IDLE;
            timer_d = '0;
         end
      endcase
      if (bus.clear_i) begin
         state_d = S_IDLE;
         timer_d = '0;
         start   = 1'b0;
      end
   end

   // Registered outputs are derived from the next state so led tracks state_q exactly
   always_comb begin
      led_d  = (state_d == S_ON);
      busy_d = (state_d != S_IDLE);
   end

   // An event and a blink start on the same edge cancel, so saturation only drops when no start
   always_comb begin
      pend_d = pend_q;
      ovf_d  = ovf_q;
      if (bus.clear_i) begin
         pend_d = '0;
         ovf_d  = 1'b0;
      end else if (bus.event_i && !start) begin
         if (pend_q == PendMax) begin
            ovf_d = 1'b1;
         end else begin
            pend_d = pend_q + 1'b1;
         end
      end else if (!bus.event_i && start) begin
         pend_d = pend_q - 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pend_q <= '0;
         ovf_q  <= 1'b0;
         led_q  <= 1'b0;
         busy_q <= 1'b0;
      end else begin
         pend_q <= pend_d;
         ovf_q  <= ovf_d;
         led_q  <= led_d;
         busy_q <= busy_d;
      end
   end

   assign bus.led_o      = led_q;
   assign bus.busy_o     = busy_q;
   assign bus.pending_o  = pend_q;
   assign bus.overflow_o = ovf_q;

endmodule

// File: tb/tb_led_blink_interface.sv
// Directed bench for led_blink_interface with OnCycles=8, OffCycles=4, PendWidth=3.
// Edge numbers in the tables count rising edges after reset release.
module tb_led_blink_interface;

   logic clock;
   logic reset;
   int   total;
   int   bad;

   led_blink_if #(.PendWidth(3)) bus ();

   led_blink_interface #(
      .OnCycles (8),
      .OffCycles(4),
      .PendWidth(3)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus.slave)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic       ev;
      int         n;
      logic       led;
      logic       busy;
      logic [2:0] pend;
      logic       ovf;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic ev, input int n, input logic led, input logic busy,
                      input int pend, input logic ovf);
      vec_t v;
      v.ev   = ev;
      v.n    = n;
      v.led  = led;
      v.busy = busy;
      v.pend = 3'(pend);
      v.ovf  = ovf;
      tbl.push_back(v);
   endtask

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
      end
   endtask

   task automatic chk_all(input string nm, input logic led, input logic busy,
                          input int pend, input logic ovf);
      chk({nm, " led"},  8'(bus.led_o),      8'(led));
      chk({nm, " busy"}, 8'(bus.busy_o),     8'(busy));
      chk({nm, " pend"}, 8'(bus.pending_o),  8'(pend));
      chk({nm, " ovf"},  8'(bus.overflow_o), 8'(ovf));
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Asserts reset between edges, checks the asynchronous clear, then releases it mid-cycle
   task automatic do_reset(input string nm);
      bus.event_i = 1'b0;
      bus.clear_i = 1'b0;
      reset = 1'b0;
      #1;
      chk_all({nm, " async reset"}, 1'b0, 1'b0, 0, 1'b0);
      tick();
      tick();
      reset = 1'b1;
   endtask

   task automatic run_tbl(input string nm, input int lo, input int hi);
      for (int i = lo; i < hi; i++) begin
         bus.event_i = tbl[i].ev;
         for (int c = 0; c < tbl[i].n; c++) begin
            tick();
            chk_all($sformatf("%s vec%0d.%0d", nm, i, c),
                    tbl[i].led, tbl[i].busy, int'(tbl[i].pend), tbl[i].ovf);
         end
      end
      bus.event_i = 1'b0;
   endtask

   int s1_lo, s1_hi, s2_lo, s2_hi, s3_lo, s3_hi;
   int low_run;
   logic any_out;

   initial begin
      total = 0;
      bad   = 0;
      reset = 1'b1;
      bus.event_i = 1'b0;
      bus.clear_i = 1'b0;

      // scenario 1: single event at edge 10
      s1_lo = tbl.size();
      add(0, 9, 0, 0, 0, 0);
      add(1, 1, 0, 0, 1, 0);
      add(0, 8, 1, 1, 0, 0);
      add(0, 4, 0, 1, 0, 0);
      add(0, 3, 0, 0, 0, 0);
      s1_hi = tbl.size();

      // scenario 2: events at edges 10, 11, 12
      s2_lo = tbl.size();
      add(0, 9, 0, 0, 0, 0);
      add(1, 1, 0, 0, 1, 0);
      add(1, 1, 1, 1, 1, 0);
      add(1, 1, 1, 1, 2, 0);
      add(0, 6, 1, 1, 2, 0);
      add(0, 4, 0, 1, 2, 0);
      add(0, 8, 1, 1, 1, 0);
      add(0, 4, 0, 1, 1, 0);
      add(0, 8, 1, 1, 0, 0);
      add(0, 4, 0, 1, 0, 0);
      add(0, 2, 0, 0, 0, 0);
      s2_hi = tbl.size();

      // scenario 3 prefix: ten events at edges 10..19, saturation at edge 18
      s3_lo = tbl.size();
      add(0, 9, 0, 0, 0, 0);
      add(1, 1, 0, 0, 1, 0);
      add(1, 1, 1, 1, 1, 0);
      for (int p = 2; p <= 7; p++) add(1, 1, 1, 1, p, 0);
      add(1, 1, 1, 1, 7, 1);
      add(1, 1, 0, 1, 7, 1);
      add(0, 3, 0, 1, 7, 1);
      s3_hi = tbl.size();

      #1;
      do_reset("s1");
      run_tbl("s1", s1_lo, s1_hi);

      do_reset("s2");
      run_tbl("s2", s2_lo, s2_hi);

      do_reset("s3");
      run_tbl("s3", s3_lo, s3_hi);
      for (int k = 1; k <= 7; k++) begin
         for (int c = 0; c < 8; c++) begin
            tick();
            chk_all($sformatf("s3 blink%0d on%0d", k, c), 1'b1, 1'b1, 7 - k, 1'b1);
         end
         for (int c = 0; c < 4; c++) begin
            tick();
            chk_all($sformatf("s3 blink%0d off%0d", k, c), 1'b0, 1'b1, 7 - k, 1'b1);
         end
      end
      tick();
      chk_all("s3 idle", 1'b0, 1'b0, 0, 1'b1);

      // scenario 4: second event lands on the last OFF cycle with nothing pending
      do_reset("s4");
      repeat (9) tick();
      bus.event_i = 1'b1;
      tick();
      bus.event_i = 1'b0;
      repeat (8) tick();
      chk_all("s4 last on", 1'b1, 1'b1, 0, 1'b0);
      low_run = 0;
      repeat (4) begin
         tick();
         if (!bus.led_o) low_run++;
      end
      chk_all("s4 last off", 1'b0, 1'b1, 0, 1'b0);
      bus.event_i = 1'b1;
      tick();
      bus.event_i = 1'b0;
      if (!bus.led_o) low_run++;
      chk_all("s4 idle gap", 1'b0, 1'b0, 1, 1'b0);
      tick();
      chk_all("s4 reblink", 1'b1, 1'b1, 0, 1'b0);
      chk("s4 low run", 8'(low_run), 8'd5);

      // scenario 5: clear during ON with pending=2, overflow=1 and a coincident event
      do_reset("s5");
      repeat (9) tick();
      bus.event_i = 1'b1;
      repeat (10) tick();
      bus.event_i = 1'b0;
      repeat (74 - 19) tick();
      chk_all("s5 pre-clear", 1'b1, 1'b1, 2, 1'b1);
      bus.clear_i = 1'b1;
      bus.event_i = 1'b1;
      tick();
      bus.clear_i = 1'b0;
      bus.event_i = 1'b0;
      chk_all("s5 post-clear", 1'b0, 1'b0, 0, 1'b0);
      any_out = 1'b0;
      repeat (30) begin
         tick();
         any_out = any_out | bus.led_o | bus.busy_o | (bus.pending_o != 3'd0);
      end
      chk("s5 quiet", 8'(any_out), 8'd0);

      // scenario 6: reset pulled low between edges in the middle of ON
      do_reset("s6a");
      repeat (9) tick();
      bus.event_i = 1'b1;
      tick();
      bus.event_i = 1'b0;
      repeat (4) tick();
      chk_all("s6 mid-on", 1'b1, 1'b1, 0, 1'b0);
      #2;
      do_reset("s6");
      run_tbl("s6", s1_lo, s1_hi);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
